// File: rtl/cache_pkg.sv
// cache_pkg: shared types and line/beat geometry for the cache-to-memory burst adaptor.
package cache_pkg;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;
    localparam int LINE_W   = 256;
    localparam int BEAT_W   = 64;
    localparam int BEATS    = 4;
    localparam int OFFSET_W = 5;
endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts a 256-bit line request into a 4 x 64-bit memory burst.
// Define CACHELINE_ADAPTOR_WRITE_EN to build the write-back path (WRITE state, buffer, burst_o).
module cacheline_adaptor
    import cache_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         mem_resp,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);
    adaptor_state_t state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic [31:0]       addr_q, addr_d;
    logic              resp_q, resp_d;
    logic              read_q, read_d;
    logic [31:0]       line_addr;
    logic              last_beat;

    assign line_addr = {pmem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
    assign last_beat = cnt_q == 2'(BEATS - 1);

`ifdef CACHELINE_ADAPTOR_WRITE_EN
    logic [LINE_W-1:0] wbuf_q, wbuf_d;
    logic [BEAT_W-1:0] bo_q, bo_d;
    logic              write_q, write_d;
    logic              unused_ok;
    assign unused_ok = ^pmem_address[OFFSET_W-1:0];
`else
    logic              unused_ok;
    assign unused_ok = ^{pmem_write, pmem_wdata, pmem_address[OFFSET_W-1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        read_d  = read_q;
        resp_d  = 1'b0;
`ifdef CACHELINE_ADAPTOR_WRITE_EN
        wbuf_d  = wbuf_q;
        bo_d    = bo_q;
        write_d = write_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef CACHELINE_ADAPTOR_WRITE_EN
                if (pmem_write) begin
                    addr_d  = line_addr;
                    wbuf_d  = pmem_wdata;
                    bo_d    = pmem_wdata[BEAT_W-1:0];
                    write_d = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = WRITE;
                end else
`endif
                if (pmem_read) begin
                    addr_d  = line_addr;
                    read_d  = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = READ;
                end
            end
            READ: if (resp_i) begin
                rdata_d[cnt_q*BEAT_W +: BEAT_W] = burst_i;
                cnt_d = cnt_q + 2'd1;
                if (last_beat) begin
                    read_d  = 1'b0;
                    resp_d  = 1'b1;
                    state_d = DONE;
                end
            end
`ifdef CACHELINE_ADAPTOR_WRITE_EN
            // burst_o is registered, so the next word is loaded as the current one is accepted
            WRITE: if (resp_i) begin
                cnt_d = cnt_q + 2'd1;
                bo_d  = wbuf_q[cnt_d*BEAT_W +: BEAT_W];
                if (last_beat) begin
                    write_d = 1'b0;
                    resp_d  = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            rdata_q <= '0;
            addr_q  <= '0;
            resp_q  <= 1'b0;
            read_q  <= 1'b0;
`ifdef CACHELINE_ADAPTOR_WRITE_EN
            wbuf_q  <= '0;
            bo_q    <= '0;
            write_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            resp_q  <= resp_d;
            read_q  <= read_d;
`ifdef CACHELINE_ADAPTOR_WRITE_EN
            wbuf_q  <= wbuf_d;
            bo_q    <= bo_d;
            write_q <= write_d;
`endif
        end
    end

    assign pmem_rdata = rdata_q;
    assign mem_resp   = resp_q;
    assign address_o  = addr_q;
    assign read_o     = read_q;
`ifdef CACHELINE_ADAPTOR_WRITE_EN
    assign burst_o    = bo_q;
    assign write_o    = write_q;
`else
    assign burst_o    = '0;
    assign write_o    = 1'b0;
`endif
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed-vector bench for cacheline_adaptor (read path, stalls, reset, back-to-back, write/ignore).
module tb_cacheline_adaptor;
    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         mem_resp;
    logic [63:0]  burst_i, burst_o;
    logic [31:0]  address_o;
    logic         read_o, write_o, resp_i;
    int           n_chk = 0, n_err = 0, resp_cnt = 0, overlap = 0, lat;

    localparam logic [63:0] W1 = 64'h1111_1111_1111_1111, W2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] W3 = 64'h3333_3333_3333_3333, W4 = 64'h4444_4444_4444_4444;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
        .mem_resp(mem_resp), .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_resp) resp_cnt++;
    always @(negedge clk) if (read_o && write_o) overlap++;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat counts the accept cycle through the mem_resp cycle inclusive
    task automatic do_read(input logic [31:0] a, input logic [63:0] b0, b1, b2, b3,
                           input int gap, output int lat_o);
        logic [63:0] bt [4];
        bt = '{b0, b1, b2, b3};
        pmem_address = a;
        pmem_read = 1'b1;
        tick();
        lat_o = 1;
        chk("read_o_rise", read_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) repeat (gap) begin resp_i = 1'b0; tick(); lat_o++; end
            resp_i = 1'b1;
            burst_i = bt[k];
            tick();
            lat_o++;
        end
        resp_i = 1'b0;
        burst_i = '0;
        for (int i = 0; i < 16 && !mem_resp; i++) begin tick(); lat_o++; end
        lat_o++;
        chk("mem_resp_seen", mem_resp, 1'b1);
        chk("read_o_drop", read_o, 1'b0);
    endtask

    initial begin
        rst = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0;
        pmem_wdata = '0; burst_i = '0; resp_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", pmem_rdata, '0);
        chk("rst_resp", mem_resp, 1'b0);
        chk("rst_read", read_o, 1'b0);
        chk("rst_write", write_o, 1'b0);
        chk("rst_addr", address_o, 32'h0);
        chk("rst_burst_o", burst_o, 64'h0);
        rst = 1'b1;
        tick();

        // gap-free read
        do_read(32'h0000_1234, W1, W2, W3, W4, 0, lat);
        chk("rd_lat", lat, 6);
        chk("rd_addr", address_o, 32'h0000_1220);
        chk("rd_line", pmem_rdata, {W4, W3, W2, W1});
        pmem_read = 1'b0;
        tick();
        chk("rd_resp_pulse", mem_resp, 1'b0);
        chk("rd_resp_cnt", resp_cnt, 1);

        // read with 3 stall cycles mid-burst
        do_read(32'h0000_0100, W4, W3, W2, W1, 3, lat);
        chk("stall_lat", lat, 9);
        chk("stall_line", pmem_rdata, {W1, W2, W3, W4});
        pmem_read = 1'b0;
        tick();

        // stray strobes in IDLE
        resp_i = 1'b1;
        burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (3) tick();
        resp_i = 1'b0;
        chk("stray_line", pmem_rdata, {W1, W2, W3, W4});
        chk("stray_resp", mem_resp, 1'b0);
        chk("stray_read", read_o, 1'b0);
        chk("stray_resp_cnt", resp_cnt, 2);

        // reset after two beats
        pmem_address = 32'h0000_0200;
        pmem_read = 1'b1;
        tick();
        resp_i = 1'b1; burst_i = 64'hAAAA_0000_0000_0001; tick();
        burst_i = 64'hAAAA_0000_0000_0002; tick();
        resp_i = 1'b0;
        pmem_read = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_read", read_o, 1'b0);
        chk("abort_rdata", pmem_rdata, '0);
        chk("abort_addr", address_o, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("abort_no_resp", resp_cnt, 2);
        do_read(32'h0000_0080, 64'h5, 64'h6, 64'h7, 64'h8, 0, lat);
        chk("fresh_addr", address_o, 32'h0000_0080);
        chk("fresh_line", pmem_rdata, {64'h8, 64'h7, 64'h6, 64'h5});

        // back-to-back: request held through DONE
        pmem_address = 32'h0000_0040;
        tick();
        chk("b2b_idle_read", read_o, 1'b0);
        chk("b2b_idle_resp", mem_resp, 1'b0);
        do_read(32'h0000_0040, W2, W2, W3, W3, 0, lat);
        chk("b2b_addr", address_o, 32'h0000_0040);
        chk("b2b_line", pmem_rdata, {W3, W3, W2, W2});
        pmem_read = 1'b0;
        tick();

`ifdef CACHELINE_ADAPTOR_WRITE_EN
        pmem_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        pmem_address = 32'h1234_5678;
        pmem_write = 1'b1;
        pmem_read = 1'b1;
        tick();
        chk("wr_write_o", write_o, 1'b1);
        chk("wr_addr", address_o, 32'h1234_5660);
        begin
            logic [63:0] wexp [4];
            wexp = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                     64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("wr_burst_o%0d", k), burst_o, wexp[k]);
                chk($sformatf("wr_read_o%0d", k), read_o, 1'b0);
                resp_i = 1'b1;
                tick();
            end
        end
        resp_i = 1'b0;
        chk("wr_resp", mem_resp, 1'b1);
        chk("wr_write_drop", write_o, 1'b0);
        pmem_write = 1'b0;
        pmem_read = 1'b0;
        tick();
        chk("wr_resp_pulse", mem_resp, 1'b0);
        chk("wr_idle_read", read_o, 1'b0);
`else
        pmem_wdata = {4{64'hFFFF_0000_FFFF_0000}};
        pmem_write = 1'b1;
        do_read(32'h0000_0360, W1, W1, W4, W4, 0, lat);
        chk("ro_lat", lat, 6);
        chk("ro_line", pmem_rdata, {W4, W4, W1, W1});
        chk("ro_write_o", write_o, 1'b0);
        chk("ro_burst_o", burst_o, 64'h0);
        pmem_write = 1'b0;
        pmem_read = 1'b0;
        tick();
`endif
        chk("no_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Upstream neighbour of the instruction cache datapath; sits between the cache's physical-memory port and the 64-bit burst memory interface.
- Converts one 256-bit line request from the cache into a 4-beat x 64-bit burst.
- Assembles read beats into the line the cache writes into its data arrays (pmem_rdata), then pulses mem_resp.
- Optional write path serialises a 256-bit victim line into 4 beats for write-back caches.

Parameters:
- BEATS, 4, beats per line (line width = BEATS*64; only 4 is supported).
- BEAT_W, 64, memory data width in bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- pmem_read  in  1  line read request from cache control, held high until mem_resp.
- pmem_write  in  1  line write request; used only with the optional feature, otherwise ignored.
- pmem_address  in  32  line address from cache; bits [4:0] ignored.
- pmem_wdata  in  256  write line; used only with the optional feature.
- pmem_rdata  out  256  assembled read line.
- mem_resp  out  1  one-cycle completion pulse to the cache.
- burst_i  in  64  memory read beat.
- burst_o  out  64  memory write beat.
- address_o  out  32  burst address, always 32-byte aligned.
- read_o  out  1  memory burst read request.
- write_o  out  1  memory burst write request.
- resp_i  in  1  memory beat strobe; each high cycle transfers exactly one beat.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, beat counter 0, pmem_rdata 0, mem_resp 0, read_o 0, write_o 0, address_o 0, burst_o 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - pmem_write high (optional feature compiled in): latch {pmem_address[31:5],5'b0} into address_o and pmem_wdata into the write buffer; go to WRITE.
  - Otherwise, pmem_read high: latch the aligned address; go to READ.
  - Write has priority when both requests are high.
- READ:
  - read_o held high; address_o stable.
  - On each cycle with resp_i high: burst_i is stored into line bits [64k+63:64k], k = counter; counter increments.
  - Beats may arrive with gaps; cycles with resp_i low change nothing.
  - On the 4th beat (k=3): read_o drops next cycle, counter wraps to 0, go to DONE.
- WRITE:
  - write_o held high; burst_o = buffer bits [64k+63:64k].
  - resp_i high advances k. After beat 3 is accepted, go to DONE.
- DONE:
  - mem_resp high for exactly one cycle; pmem_rdata is valid in that cycle.
  - Unconditional return to IDLE.
  - The earliest next request is accepted in the IDLE cycle after DONE, so back-to-back lines cost 1 idle cycle.
- Latency: a read with gap-free beats starting the cycle after read_o rises takes 1 (accept) + 4 beats + 1 (DONE) = mem_resp 6 cycles after pmem_read is sampled.
- pmem_rdata holds the last line until the next read's first beat overwrites it.
- Request inputs are not re-sampled mid-burst. Changing pmem_address or dropping pmem_read during a burst has no effect; the burst completes and mem_resp still pulses.
- resp_i high in IDLE or DONE is ignored.
- Reset mid-burst aborts immediately to IDLE with reset outputs; no mem_resp is issued.
- read_o and write_o are never high together.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_WRITE_EN.
- Defined: the WRITE state, the write buffer and burst_o are built, and pmem_write is honoured with priority over pmem_read.
- Undefined: WRITE is not built, pmem_write and pmem_wdata are ignored, burst_o and write_o are tied to 0. This is the read-only configuration used by the icache.

Decomposition:
- Shared package cache_pkg: adaptor_state_t enum {IDLE, READ, WRITE, DONE}; LINE_W=256, BEAT_W=64, BEATS=4, OFFSET_W=5.
- No sub-module is needed. Beat indexing is an indexed part-select on the 2-bit counter; the FSM and datapath fit in one module.

Test Plan:
- Read, gap-free: pmem_read with pmem_address=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220; pmem_rdata={0x44..,0x33..,0x22..,0x11..}; mem_resp a single pulse 6 cycles after request.
- Read with stalls: resp_i low for 3 cycles between beats 1 and 2 -> same line assembled; mem_resp delayed by exactly 3 cycles.
- Reset mid-burst: rst low after beat 2 -> read_o=0, no mem_resp. A following read of 0x80 completes with fresh data, and no stale beats leak into the new line.
- Back-to-back: second pmem_read to 0x40 held through DONE -> accepted in the next IDLE cycle; 1 idle cycle between read_o pulses.
- Write (macro defined): pmem_write with pmem_wdata=0xDDDD...AAAA (4 distinct words) and pmem_read both high -> write_o first; burst_o sequence is word0..word3; mem_resp after beat 3; read_o stays 0 throughout.
- Stray strobe: resp_i high in IDLE -> pmem_rdata unchanged, mem_resp stays 0.
